rib_arbiter: RTL and testbench

RIB_ARBITER -- requirements
Module: rib_arbiter

---
 rtl/rib_arbiter.sv | 163 ++++++++++++++++
 tb/tb_rib_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/rib_arbiter.sv
// rtl/rib_arbiter.sv - three-master bus arbiter with grant timeout; RIB_ARB_RR_EN selects round-robin
module rib_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] m_req,
  input  logic       s_ack,
  output logic [2:0] gnt,
  output logic [1:0] gnt_id,
  output logic       busy,
  output logic [2:0] hold,
  output logic       err,
  output logic [1:0] err_id
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t           r_state, w_state_n;
  logic [2:0]       r_gnt, w_gnt_n;
  logic [1:0]       r_gnt_id, w_gnt_id_n;
  logic [CNT_W-1:0] r_cnt, w_cnt_n;
  logic             r_err, w_err_n;
  logic [1:0]       r_err_id, w_err_id_n;

  logic             w_rearb;
  logic             w_own_req;
  logic             w_timeout;
  logic [2:0]       w_oth_req;
  logic [2:0]       w_pick_oth;
  logic [2:0]       w_win;

  // One-hot to index; only ever called with a one-hot or zero vector
  function automatic logic [1:0] f_enc(input logic [2:0] oh);
    logic [1:0] id;
    id = 2'd0;
    if (oh[2])      id = 2'd2;
    else if (oh[1]) id = 2'd1;
    return id;
  endfunction

`ifdef RIB_ARB_RR_EN
  logic [1:0] r_rr_last;
  logic [1:0] w_rr_start;

  // Rotating search starting at master 'start'
  function automatic logic [2:0] f_pick(input logic [2:0] req, input logic [1:0] start);
    logic [2:0] f;
    case (start)
      2'd0:    f = req[0] ? 3'b001 : req[1] ? 3'b010 : req[2] ? 3'b100 : 3'b000;
      2'd1:    f = req[1] ? 3'b010 : req[2] ? 3'b100 : req[0] ? 3'b001 : 3'b000;
      default: f = req[2] ? 3'b100 : req[0] ? 3'b001 : req[1] ? 3'b010 : 3'b000;
    endcase
    return f;
  endfunction

  assign w_rr_start = (r_rr_last == 2'd2) ? 2'd0 : r_rr_last + 2'd1;
  assign w_pick_oth = f_pick(w_oth_req, w_rr_start);
`else
  // Fixed priority m2 > m1 > m0
  function automatic logic [2:0] f_pick(input logic [2:0] req);
    logic [2:0] f;
    f = req[2] ? 3'b100 : req[1] ? 3'b010 : req[0] ? 3'b001 : 3'b000;
    return f;
  endfunction

  assign w_pick_oth = f_pick(w_oth_req);
`endif

  // The current holder only wins when nobody else is asking (lowest priority at release).
  // In IDLE r_gnt is zero, so every requester counts as "other".
  assign w_oth_req = m_req & ~r_gnt;
  assign w_own_req = |(m_req & r_gnt);
  assign w_win     = (|w_pick_oth) ? w_pick_oth : (m_req & r_gnt);

  // Counter starts at 0 on the first grant cycle, so the grant is released after TIMEOUT-1 cycles
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 2));

  // Next-state: grant, release, abort and timeout decisions
  always_comb begin
    w_state_n  = r_state;
    w_gnt_n    = r_gnt;
    w_gnt_id_n = r_gnt_id;
    w_cnt_n    = r_cnt;
    w_err_n    = 1'b0;
    w_err_id_n = r_err_id;
    w_rearb    = 1'b0;
    case (r_state)
      ST_IDLE: w_rearb = 1'b1;
      ST_BUSY: begin
        if (s_ack) begin
          w_rearb = 1'b1;
        end else if (!w_own_req) begin
          w_state_n  = ST_IDLE;
          w_gnt_n    = 3'b000;
          w_gnt_id_n = 2'd0;
          w_cnt_n    = '0;
        end else if (w_timeout) begin
          w_rearb    = 1'b1;
          w_err_n    = 1'b1;
          w_err_id_n = r_gnt_id;
        end else begin
          w_cnt_n = r_cnt + 1'b1;
        end
      end
      default: w_state_n = ST_IDLE;
    endcase
    if (w_rearb) begin
      w_cnt_n = '0;
      if (|w_win) begin
        w_state_n  = ST_BUSY;
        w_gnt_n    = w_win;
        w_gnt_id_n = f_enc(w_win);
      end else begin
        w_state_n  = ST_IDLE;
        w_gnt_n    = 3'b000;
        w_gnt_id_n = 2'd0;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_gnt    <= 3'b000;
      r_gnt_id <= 2'd0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
      r_err_id <= 2'd0;
    end else begin
      r_state  <= w_state_n;
      r_gnt    <= w_gnt_n;
      r_gnt_id <= w_gnt_id_n;
      r_cnt    <= w_cnt_n;
      r_err    <= w_err_n;
      r_err_id <= w_err_id_n;
    end
  end

`ifdef RIB_ARB_RR_EN
  // Round-robin pointer follows every new grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_last <= 2'd1;
    end else if (w_rearb && (|w_win)) begin
      r_rr_last <= f_enc(w_win);
    end
  end
`endif

  assign gnt    = r_gnt;
  assign gnt_id = r_gnt_id;
  assign busy   = |r_gnt;
  assign hold   = m_req & ~r_gnt;
  assign err    = r_err;
  assign err_id = r_err_id;

endmodule

// File: tb/tb_rib_arbiter.sv
// tb/tb_rib_arbiter.sv - directed self-checking bench for rib_arbiter
module tb_rib_arbiter;

  logic       clk;
  logic       rst;
  logic [2:0] m_req;
  logic       s_ack;
  logic [2:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic [2:0] hold;
  logic       err;
  logic [1:0] err_id;

  int n_vec;
  int n_err;

  rib_arbiter #(.TIMEOUT(16), .CNT_W(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .m_req  (m_req),
    .s_ack  (s_ack),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .busy   (busy),
    .hold   (hold),
    .err    (err),
    .err_id (err_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    m_req = 3'b000;
    s_ack = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    m_req = 3'b111;
    s_ack = 1'b1;
    tick();
    tick();
    n_vec++; if (gnt !== 3'b000) begin n_err++; $display("FAIL reset_gnt actual=%b required=000", gnt); end
    n_vec++; if (gnt_id !== 2'd0) begin n_err++; $display("FAIL reset_gnt_id actual=%0d required=0", gnt_id); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy actual=%b required=0", busy); end
    n_vec++; if (err !== 1'b0 || err_id !== 2'd0) begin n_err++; $display("FAIL reset_err actual=%b/%0d required=0/0", err, err_id); end
    n_vec++; if (hold !== 3'b111) begin n_err++; $display("FAIL reset_hold actual=%b required=111", hold); end
    rst   = 1'b0;
    m_req = 3'b000;
    s_ack = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [2:0] first, second;
`ifdef RIB_ARB_RR_EN
    first  = 3'b001;
    second = 3'b010;
`else
    first  = 3'b010;
    second = 3'b001;
`endif
    do_reset();
    m_req = 3'b011;
    tick();
    n_vec++; if (gnt !== first) begin n_err++; $display("FAIL basic_first_gnt actual=%b required=%b", gnt, first); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy actual=%b required=1", busy); end
    n_vec++; if (hold !== (3'b011 & ~first)) begin n_err++; $display("FAIL basic_hold actual=%b required=%b", hold, 3'b011 & ~first); end
    s_ack = 1'b1;
    tick();
    n_vec++; if (gnt !== second) begin n_err++; $display("FAIL basic_no_bubble actual=%b required=%b", gnt, second); end
    n_vec++; if (gnt_id !== ((second == 3'b010) ? 2'd1 : 2'd0)) begin n_err++; $display("FAIL basic_gnt_id actual=%0d", gnt_id); end
    m_req = 3'b000;
    tick();
    n_vec++; if (gnt !== 3'b000 || busy !== 1'b0) begin n_err++; $display("FAIL basic_idle actual=%b/%b required=000/0", gnt, busy); end
    s_ack = 1'b0;
  endtask

  task automatic test_priority();
    logic [2:0] exp_seq [6];
`ifdef RIB_ARB_RR_EN
    exp_seq = '{3'b100, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
`else
    exp_seq = '{3'b100, 3'b010, 3'b100, 3'b010, 3'b100, 3'b010};
`endif
    do_reset();
    m_req = 3'b111;
    s_ack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_vec++;
      if (gnt !== exp_seq[i] || hold !== (3'b111 & ~exp_seq[i])) begin
        n_err++;
        $display("FAIL priority_seq[%0d] actual gnt=%b hold=%b required gnt=%b hold=%b",
                 i, gnt, hold, exp_seq[i], 3'b111 & ~exp_seq[i]);
      end
    end
    m_req = 3'b000;
    tick();
    s_ack = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    m_req = 3'b010;
    tick();
    n_vec++; if (gnt !== 3'b010) begin n_err++; $display("FAIL to_grant actual=%b required=010", gnt); end
    m_req = 3'b011;
    for (int c = 2; c <= 15; c++) begin
      tick();
      n_vec++;
      if (gnt !== 3'b010 || err !== 1'b0) begin
        n_err++;
        $display("FAIL to_hold_cycle%0d actual gnt=%b err=%b required gnt=010 err=0", c, gnt, err);
      end
    end
    tick();
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL to_err_pulse actual=%b required=1", err); end
    n_vec++; if (err_id !== 2'd1) begin n_err++; $display("FAIL to_err_id actual=%0d required=1", err_id); end
    n_vec++; if (gnt !== 3'b001) begin n_err++; $display("FAIL to_release actual=%b required=001", gnt); end
    tick();
    n_vec++; if (err !== 1'b0 || err_id !== 2'd1) begin n_err++; $display("FAIL to_pulse_end actual=%b/%0d required=0/1", err, err_id); end
    m_req = 3'b000;
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0;

    do_reset();
    m_req = 3'b010;
    tick();
    for (int c = 2; c <= 15; c++) tick();
    m_req = 3'b000;
    s_ack = 1'b1;
    tick();
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL ack_beats_timeout actual err=%b required=0", err); end
    n_vec++; if (gnt !== 3'b000) begin n_err++; $display("FAIL ack_release actual=%b required=000", gnt); end
    s_ack = 1'b0;
  endtask

  task automatic test_abort();
    do_reset();
    m_req = 3'b001;
    tick();
    n_vec++; if (gnt !== 3'b001) begin n_err++; $display("FAIL abort_grant actual=%b required=001", gnt); end
    m_req = 3'b000;
    tick();
    n_vec++; if (gnt !== 3'b000 || err !== 1'b0) begin n_err++; $display("FAIL abort_drop actual gnt=%b err=%b required 000/0", gnt, err); end

    m_req = 3'b001;
    tick();
    n_vec++; if (gnt !== 3'b001) begin n_err++; $display("FAIL rstbusy_grant actual=%b required=001", gnt); end
    #2;
    rst = 1'b1;
    #1;
    n_vec++; if (gnt !== 3'b000 || busy !== 1'b0 || err !== 1'b0) begin n_err++; $display("FAIL rst_async actual gnt=%b busy=%b err=%b required 000/0/0", gnt, busy, err); end
    tick();
    rst = 1'b0;
    tick();
    n_vec++; if (gnt !== 3'b001) begin n_err++; $display("FAIL post_rst_grant actual=%b required=001", gnt); end
    m_req = 3'b000;
    tick();
  endtask

  task automatic test_idle_ack();
    do_reset();
    s_ack = 1'b1;
    tick();
    tick();
    n_vec++; if (gnt !== 3'b000 || err !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL idle_ack actual gnt=%b err=%b busy=%b required 000/0/0", gnt, err, busy); end
    s_ack = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    m_req = 3'b000;
    s_ack = 1'b0;
    test_reset();
    test_basic();
    test_priority();
    test_timeout();
    test_abort();
    test_idle_ack();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
